instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_if.sv | 10 +
 rtl/instruction_fetch_unit.sv | 100 ++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-decode handshake: head instruction, its address, valid/ready.
interface instruction_fetch_unit_if;
   logic [31:0] InstrOut;
   logic [63:0] PCOut;
   logic        Valid;
   logic        Ready;

   modport master (output InstrOut, output PCOut, output Valid, input Ready);
   modport slave  (input InstrOut, input PCOut, input Valid, output Ready);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register, 2-entry instruction queue, halts on a
// zero word until redirected.
module instruction_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        CLK,
   input  logic        RESET_N,
   output logic [63:0] Address,
   input  logic [31:0] Data,
   input  logic        Redirect,
   input  logic [63:0] RedirectPC,
   output logic        Halted,
   output logic [31:0] FetchCount,
   instruction_fetch_unit_if.master dec
);

   typedef enum logic {FETCH, HALTED} state_t;

   state_t      state, state_nxt;
   logic [63:0] fetch_pc;
   logic [63:0] pc0, pc1;
   logic [31:0] ins0, ins1;
   logic [1:0]  count;
   logic        pop, space, push;
   logic        rpc_unused;

   assign rpc_unused = ^RedirectPC[1:0];

   assign dec.Valid    = (count != 2'd0);
   assign dec.InstrOut = ins0;
   assign dec.PCOut    = pc0;
   assign Address      = fetch_pc;
   assign Halted       = (state == HALTED);

   always_comb begin
      pop       = dec.Valid && dec.Ready;
      space     = (count != 2'd2) || pop;
      push      = 1'b0;
      state_nxt = state;
      if (Redirect) begin
         state_nxt = FETCH;
      end else if (state == FETCH && space) begin
         if (Data != 32'h0) push = 1'b1;
         else               state_nxt = HALTED;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= FETCH;
      else          state <= state_nxt;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         fetch_pc   <= RESET_PC;
         count      <= 2'd0;
         pc0        <= 64'h0;
         pc1        <= 64'h0;
         ins0       <= 32'h0;
         ins1       <= 32'h0;
         FetchCount <= 32'h0;
      end else begin
         if (push) FetchCount <= FetchCount + 32'd1;
         if (Redirect) begin
            fetch_pc <= {RedirectPC[63:2], 2'b00};
            count    <= 2'd0;
         end else begin
            if (push) fetch_pc <= fetch_pc + 64'd4;
            // Entry 0 is the head; it keeps its value when the queue empties
            if (pop && push) begin
               if (count == 2'd2) begin
                  pc0  <= pc1;
                  ins0 <= ins1;
                  pc1  <= fetch_pc;
                  ins1 <= Data;
               end else begin
                  pc0  <= fetch_pc;
                  ins0 <= Data;
               end
            end else if (pop) begin
               if (count == 2'd2) begin
                  pc0  <= pc1;
                  ins0 <= ins1;
               end
               count <= count - 2'd1;
            end else if (push) begin
               if (count == 2'd0) begin
                  pc0  <= fetch_pc;
                  ins0 <= Data;
               end else begin
                  pc1  <= fetch_pc;
                  ins1 <= Data;
               end
               count <= count + 2'd1;
            end
         end
      end
   end

endmodule
